// File: rtl/pmodamp2_pkg.sv
// pmodamp2_pkg: shared states, gain codes and sample conversion for the PmodAMP2 transmitter.
package pmodamp2_pkg;
    typedef enum logic [1:0] {S_OFF, S_WAKE, S_RUN} state_t;
    localparam logic [1:0] GAIN_X0 = 2'b00;
    localparam logic [1:0] GAIN_X1 = 2'b01;
    localparam logic [1:0] GAIN_X2 = 2'b10;
    localparam logic [1:0] GAIN_X3 = 2'b11;
    // Two's complement to offset binary: flip the sign bit of a w-bit sample.
    function automatic logic [31:0] to_offset(input logic [31:0] s, input int w);
        return s ^ (32'd1 << (w - 1));
    endfunction
endpackage

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: prescaler and PWM period counter; flags the last tick of each period.
module pwm_tick_gen #(
    parameter int SAMPLE_W = 8,
    parameter int PRESC    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clr,
    output logic                o_boundary,
    output logic [SAMPLE_W-1:0] o_pwm_cnt
);
    localparam int PW = PRESC > 1 ? $clog2(PRESC) : 1;
    logic [PW-1:0]       r_presc;
    logic [SAMPLE_W-1:0] r_pwm;
    logic                w_tick;
    assign w_tick     = r_presc == PW'(PRESC - 1);
    assign o_boundary = w_tick && (&r_pwm);
    assign o_pwm_cnt  = r_pwm;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_pwm   <= '0;
        end else if (i_clr) begin
            r_presc <= '0;
            r_pwm   <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) r_pwm <= r_pwm + 1'b1;
        end
    end
endmodule

// File: rtl/pmodamp2_pwm_tx.sv
// pmodamp2_pwm_tx: PCM stream to PWM for the PmodAMP2, with power-up sequencing of SHUTDOWN/GAIN.
module pmodamp2_pwm_tx import pmodamp2_pkg::*; #(
    parameter int SAMPLE_W     = 8,
    parameter int PRESC        = 4,
    parameter int WAKE_PERIODS = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          gain_sel,
    input  logic                s_valid,
    input  logic [SAMPLE_W-1:0] s_data,
    output logic                s_ready,
    output logic                AIN,
    output logic [1:0]          GAIN,
    output logic                SHUTDOWN,
    output logic                underrun,
    output logic                running
);
    localparam logic [SAMPLE_W-1:0] MID = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam int WW = $clog2(WAKE_PERIODS + 1);
    state_t              r_state, w_next;
    logic                r_stop, r_full, r_ain, r_und, w_bnd, w_hs;
    logic [1:0]          r_gain;
    logic [WW-1:0]       r_wake;
    logic [SAMPLE_W-1:0] r_hold, r_duty, w_pwm, w_hold_duty, w_in_duty;
    pwm_tick_gen #(.SAMPLE_W(SAMPLE_W), .PRESC(PRESC)) u_tick (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (r_state == S_OFF),
        .o_boundary (w_bnd),
        .o_pwm_cnt  (w_pwm)
    );
    assign w_hold_duty = SAMPLE_W'(to_offset(32'(r_hold), SAMPLE_W));
    assign w_in_duty   = SAMPLE_W'(to_offset(32'(s_data), SAMPLE_W));
    // A pending stop blocks new samples; the boundary itself always frees a slot.
    assign s_ready  = r_state == S_RUN && !r_stop && (!r_full || w_bnd);
    assign w_hs     = s_valid && s_ready;
    assign AIN      = r_ain;
    assign GAIN     = r_gain;
    assign SHUTDOWN = r_state != S_OFF;
    assign underrun = r_und;
    assign running  = r_state == S_RUN;
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_OFF:   w_next = en ? S_WAKE : S_OFF;
            S_WAKE:  w_next = !en ? S_OFF : (w_bnd && r_wake == WW'(WAKE_PERIODS - 1)) ? S_RUN : S_WAKE;
            S_RUN:   w_next = (w_bnd && r_stop) ? S_OFF : S_RUN;
            default: w_next = S_OFF;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_OFF;
            r_stop  <= 1'b0;
            r_full  <= 1'b0;
            r_hold  <= '0;
            r_duty  <= MID;
            r_wake  <= '0;
            r_gain  <= GAIN_X0;
            r_ain   <= 1'b0;
            r_und   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ain   <= r_state != S_OFF && w_pwm < r_duty;
            r_und   <= 1'b0;
            r_wake  <= r_state != S_WAKE ? '0 : r_wake + WW'(w_bnd);
            r_stop  <= r_state == S_RUN && w_next == S_RUN && (r_stop || !en);
            if (r_state == S_OFF) r_gain <= gain_sel;
            if (w_next != S_RUN) begin
                r_full <= 1'b0;
                r_duty <= MID;
            end else if (r_state == S_RUN) begin
                if (w_bnd) begin
                    r_duty <= r_full ? w_hold_duty : w_hs ? w_in_duty : MID;
                    r_und  <= !r_full && !w_hs;
                    r_full <= r_full && w_hs;
                    if (w_hs) r_hold <= s_data;
                end else if (w_hs) begin
                    r_hold <= s_data;
                    r_full <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pmodamp2_pwm_tx.sv
// tb_pmodamp2_pwm_tx: directed stimulus, per-cycle check against a period/queue model, plus literal pins.
module tb_pmodamp2_pwm_tx;
    localparam int SW = 4, PR = 2, WP = 2;
    localparam int PER = PR * (1 << SW), RUNC = WP * PER, MIDV = 1 << (SW - 1);
    logic clk = 0, rst = 1, en = 0, s_valid = 0;
    logic [1:0] gain_sel = 0;
    logic [SW-1:0] s_data = 0;
    logic s_ready, AIN, SHUTDOWN, underrun, running;
    logic [1:0] GAIN;
    int n_chk = 0, n_pass = 0, und_cnt = 0, hs_n = 0;
    int hi[32];
    bit cmp_en = 0;
    bit m_on = 0, m_stop = 0, m_ain = 0, m_und = 0;
    int m_c = 0, m_duty = MIDV, m_gain = 0;
    int m_q[$];

    pmodamp2_pwm_tx #(.SAMPLE_W(SW), .PRESC(PR), .WAKE_PERIODS(WP)) dut (
        .clk(clk), .rst(rst), .en(en), .gain_sel(gain_sel), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .AIN(AIN), .GAIN(GAIN), .SHUTDOWN(SHUTDOWN), .underrun(underrun), .running(running)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string n, input int a, input int e);
        n_chk++;
        if (a == e) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", n, a, e, $time);
    endtask

    function automatic bit m_bnd();
        return m_on && (m_c % PER == PER - 1);
    endfunction

    function automatic bit m_rdy();
        return m_on && m_c >= RUNC && !m_stop && (m_q.size() == 0 || m_bnd());
    endfunction

    // Reference: time since wake fixes the PWM phase; accepted samples queue up and one is consumed per boundary.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_on = 0; m_stop = 0; m_ain = 0; m_und = 0; m_c = 0; m_duty = MIDV; m_gain = 0;
            m_q.delete();
        end else begin
            bit bnd, run, hs, ain_n, und_n;
            bnd = m_bnd();
            run = m_on && m_c >= RUNC;
            hs = m_rdy() && s_valid;
            ain_n = m_on && ((m_c % PER) / PR < m_duty);
            und_n = 0;
            if (!m_on) begin
                m_gain = gain_sel;
                if (en) begin m_on = 1; m_c = 0; end
            end else if (!run) begin
                if (!en) m_on = 0;
                else m_c++;
            end else if (bnd && m_stop) begin
                m_on = 0; m_stop = 0; m_duty = MIDV;
                m_q.delete();
            end else begin
                if (hs) m_q.push_back(int'($signed(s_data)) + MIDV);
                if (bnd) begin
                    if (m_q.size() > 0) m_duty = m_q.pop_front();
                    else begin m_duty = MIDV; und_n = 1; end
                end
                if (!en) m_stop = 1;
                m_c++;
            end
            m_ain = ain_n;
            m_und = und_n;
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            cmp("AIN", AIN, m_ain);
            cmp("underrun", underrun, m_und);
            cmp("SHUTDOWN", SHUTDOWN, m_on);
            cmp("running", running, m_on && m_c >= RUNC);
            cmp("GAIN", GAIN, m_gain);
            cmp("s_ready", s_ready, m_rdy());
        end
        if (underrun) und_cnt++;
        if (m_on && m_c == 0) for (int i = 0; i < 32; i++) hi[i] = 0;
        else if (m_on && AIN && (m_c - 1) / PER < 32) hi[(m_c - 1) / PER]++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_c(input int n);
        for (int k = 0; k < 2000 && !(m_on && m_c == n); k++) step();
        if (!(m_on && m_c == n)) begin
            n_chk++;
            $display("FAIL wait_c: cycle %0d never reached (at %0d)", n, m_c);
        end
    endtask

    task automatic send(input int v);
        bit ok = 0;
        s_valid = 1;
        s_data = SW'(v);
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
        end
        #1;
        s_valid = 0;
        if (!ok) begin
            n_chk++;
            $display("FAIL send: sample %0d never accepted", v);
        end
    endtask

    initial begin
        step();
        cmp_en = 1;
        repeat (2) step();
        rst = 0;
        step();
        cmp("rst_shdn", SHUTDOWN, 0);
        cmp("rst_gain", GAIN, 0);
        cmp("rst_ready", s_ready, 0);
        cmp("rst_ain", AIN, 0);
        gain_sel = 2'b10;
        step();
        cmp("off_gain", GAIN, 2);
        en = 1;
        step();
        cmp("wake_shdn", SHUTDOWN, 1);
        gain_sel = 2'b01;
        send(-8);
        cmp("run_after_wake", running, 1);
        cmp("gain_frozen", GAIN, 2);
        cmp("wake_p0", hi[0], 16);
        cmp("wake_p1", hi[1], 16);
        send(0);
        send(7);
        send(-1);
        wait_c(230);
        cmp("p2_mid", hi[2], 16);
        cmp("p3_m8", hi[3], 0);
        cmp("p4_0", hi[4], 16);
        cmp("p5_p7", hi[5], 30);
        cmp("p6_m1", hi[6], 14);
        cmp("und_once", und_cnt, 1);
        wait_c(255);
        cmp("bypass_ready", s_ready, 1);
        s_valid = 1;
        s_data = 4'd3;
        step();
        s_data = SW'(-4);
        for (int k = 0; k < 128; k++) begin
            bit ok;
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            if (ok) begin hs_n++; s_data = s_data + 1'b1; end
        end
        s_valid = 0;
        cmp("bp_handshakes", hs_n, 5);
        wait_c(420);
        cmp("p7_und_mid", hi[7], 16);
        cmp("p8_bypass", hi[8], 22);
        cmp("p9_bp", hi[9], 8);
        cmp("p10_bp", hi[10], 10);
        cmp("p11_bp", hi[11], 12);
        cmp("p12_bp", hi[12], 14);
        cmp("und_still_once", und_cnt, 1);
        cmp("stop_ready_pre", s_ready, 1);
        en = 0;
        step();
        cmp("stop_ready", s_ready, 0);
        wait_c(447);
        cmp("stop_run_last", running, 1);
        step();
        cmp("stop_shdn", SHUTDOWN, 0);
        cmp("stop_ain", AIN, 0);
        cmp("stop_running", running, 0);
        cmp("p13_last", hi[13], 16);
        cmp("stop_no_und", und_cnt, 1);
        cmp("stop_gain_held", GAIN, 2);
        step();
        cmp("off_gain_new", GAIN, 1);
        en = 1;
        step();
        cmp("rewake_shdn", SHUTDOWN, 1);
        cmp("rewake_running", running, 0);
        wait_c(70);
        cmp("rewake_run", running, 1);
        cmp("rewake_p0", hi[0], 16);
        cmp("rewake_p1", hi[1], 16);
        s_valid = 1;
        s_data = 4'd5;
        step();
        s_valid = 0;
        cmp("pre_rst_ain", AIN, 1);
        #2 rst = 1;
        #1;
        cmp("async_shdn", SHUTDOWN, 0);
        cmp("async_ain", AIN, 0);
        cmp("async_gain", GAIN, 0);
        cmp("async_ready", s_ready, 0);
        cmp("async_running", running, 0);
        step();
        rst = 0;
        step();
        cmp("post_rst_ready", s_ready, 0);
        repeat (5) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
